// File: rtl/handshake_ctrl_if.sv
// -----------------------------------------------------------------------------
// handshake_ctrl_if
// Bundles the update strobes, acknowledges, mask/clear controls and the status
// outputs of handshake_ctrl. The interface carries no clock or reset.
//   master : update source / register side (drives strobes, acks, mask, clear)
//   slave  : handshake_ctrl (drives pending bits, int_req, int_id, ovf_cnt)
// Signals:
//   IO_BotUpdt      [NUM_CH]       asynchronous update strobes
//   IO_INT_ACK      [NUM_CH]       synchronous per-channel acknowledge
//   int_mask        [NUM_CH]       1 = channel excluded from int_req/int_id
//   ovf_clr                        synchronous clear of all overrun counters
//   IO_BotUpdt_Sync [NUM_CH]       sticky pending bits
//   int_req                        any unmasked channel pending
//   int_id          [ID_W]         lowest unmasked pending channel
//   ovf_cnt         [NUM_CH*OVF_W] per-channel saturating overrun counters
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface handshake_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int OVF_W  = 8
);
   localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]       IO_BotUpdt;
   logic [NUM_CH-1:0]       IO_INT_ACK;
   logic [NUM_CH-1:0]       int_mask;
   logic                    ovf_clr;
   logic [NUM_CH-1:0]       IO_BotUpdt_Sync;
   logic                    int_req;
   logic [ID_W-1:0]         int_id;
   logic [NUM_CH*OVF_W-1:0] ovf_cnt;

   modport master (
      output IO_BotUpdt, IO_INT_ACK, int_mask, ovf_clr,
      input  IO_BotUpdt_Sync, int_req, int_id, ovf_cnt
   );

   modport slave (
      input  IO_BotUpdt, IO_INT_ACK, int_mask, ovf_clr,
      output IO_BotUpdt_Sync, int_req, int_id, ovf_cnt
   );
endinterface

// File: rtl/handshake_ctrl.sv
// -----------------------------------------------------------------------------
// handshake_ctrl
// Multi-channel update handshake. Each asynchronous update strobe is
// synchronised into clk50, turned into a set event (rising edge or level),
// and latched into a sticky pending bit that only its own acknowledge clears.
// A registered, masked, lowest-index-first interrupt request/id is produced,
// and every set that lands on an already pending, un-acked channel is counted
// in a per-channel saturating overrun counter.
// Ports:
//   clk50    system clock, rising edge
//   reset_n  asynchronous active-low reset, clears all state
//   hs       handshake_ctrl_if.slave (strobes, acks, mask, clear, status)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module handshake_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1,
   parameter int OVF_W       = 8
) (
   input  logic             clk50,
   input  logic             reset_n,
   handshake_ctrl_if.slave  hs
);
   localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]       r_sync [SYNC_STAGES];
   logic [NUM_CH-1:0]       r_hist;
   logic [NUM_CH-1:0]       r_pend;
   logic [OVF_W-1:0]        r_ovf  [NUM_CH];
   logic                    r_int_req;
   logic [ID_W-1:0]         r_int_id;

   logic [NUM_CH-1:0]       w_set;
   logic [NUM_CH-1:0]       w_ovf_inc;
   logic [NUM_CH-1:0]       w_unmasked;
   logic [ID_W-1:0]         w_first_id;
   logic [NUM_CH*OVF_W-1:0] w_ovf_flat;

   // Synchroniser chain plus one history flop behind the last stage, used for
   // edge detection. History resets to 0, so an input held high across reset
   // release yields exactly one edge.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_hist <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the value of
         // its predecessor from before this edge, which is what forms the chain.
         r_sync[0] <= hs.IO_BotUpdt;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_set = (EDGE_MODE != 0) ? (r_sync[SYNC_STAGES-1] & ~r_hist)
                                   : r_sync[SYNC_STAGES-1];

   // A set with a same-cycle ack is a fresh event, not a missed one.
   assign w_ovf_inc  = w_set & r_pend & ~hs.IO_INT_ACK;
   assign w_unmasked = r_pend & ~hs.int_mask;

   // Set wins over ack so an event arriving with the ack is never lost.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) r_pend <= '0;
      else          r_pend <= (r_pend & ~hs.IO_INT_ACK) | w_set;
   end

   // NOTE: the counter array is a handful of flops, not a RAM, so it takes the
   // async reset like any other state; a reset must discard stale counts.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) r_ovf[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (hs.ovf_clr)
               r_ovf[i] <= '0;
            else if (w_ovf_inc[i] && (r_ovf[i] != '1))
               r_ovf[i] <= r_ovf[i] + 1'b1;
         end
      end
   end

   // Lowest-index priority: scan downwards so the last hit is the smallest.
   always_comb begin
      // NOTE: default first so every path assigns w_first_id and no latch forms.
      w_first_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_unmasked[i]) w_first_id = ID_W'(i);
      end
   end

   // int_id only follows while something is requesting; otherwise it keeps the
   // last reported channel.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         r_int_req <= 1'b0;
         r_int_id  <= '0;
      end else begin
         r_int_req <= |w_unmasked;
         if (|w_unmasked) r_int_id <= w_first_id;
      end
   end

   always_comb begin
      w_ovf_flat = '0;
      for (int i = 0; i < NUM_CH; i++) w_ovf_flat[i*OVF_W +: OVF_W] = r_ovf[i];
   end

   assign hs.IO_BotUpdt_Sync = r_pend;
   assign hs.int_req         = r_int_req;
   assign hs.int_id          = r_int_id;
   assign hs.ovf_cnt         = w_ovf_flat;

endmodule
